// File: rtl/fxp_pkg.sv
// Shared types, widths and the rescale/saturate helper for the fixed-point MAC.
// Build option: FXP_MAC_ROUND_EN selects round-half-up rescaling. When it is
// undefined, rescaling truncates toward -infinity.
package fxp_pkg;

   localparam int FXP_WIDTH_INPUT    = 16;
   localparam int FXP_WIDTH_FRACTION = 9;
   localparam int FXP_WIDTH_ACC      = 40;
   localparam int FXP_WIDTH_CNT      = 8;
   localparam int FXP_MAC_LATENCY    = 3;

   typedef logic signed [FXP_WIDTH_INPUT-1:0]   fxp_in_t;
   typedef logic signed [2*FXP_WIDTH_INPUT-1:0] fxp_prod_t;
   typedef logic signed [FXP_WIDTH_ACC-1:0]     fxp_acc_t;

   // Clip limits of the output format, held at accumulator+1 width for comparison.
   localparam logic signed [FXP_WIDTH_ACC:0] FXP_SAT_MAX =
      (FXP_WIDTH_ACC+1)'((2**(FXP_WIDTH_INPUT-1)) - 1);
   localparam logic signed [FXP_WIDTH_ACC:0] FXP_SAT_MIN =
      (FXP_WIDTH_ACC+1)'(-(2**(FXP_WIDTH_INPUT-1)));

   // Rescale a full-precision sum back to the operand Q-format and clip it.
   // The sum is widened by one bit first, so the rounding add cannot wrap.
   // The result is packed as {sat, value}.
   function automatic logic [FXP_WIDTH_INPUT:0] fxp_sat(input fxp_acc_t    acc,
                                                        input int unsigned frac,
                                                        input logic        round);
      logic signed [FXP_WIDTH_ACC:0] w_ext;
      logic signed [FXP_WIDTH_ACC:0] w_shift;
      w_ext = {acc[FXP_WIDTH_ACC-1], acc};
      if (round && (frac != 0))
         w_ext = w_ext + ((FXP_WIDTH_ACC+1)'(1) << (frac - 1));
      w_shift = w_ext >>> frac;
      if (w_shift > FXP_SAT_MAX)
         return {1'b1, FXP_SAT_MAX[FXP_WIDTH_INPUT-1:0]};
      else if (w_shift < FXP_SAT_MIN)
         return {1'b1, FXP_SAT_MIN[FXP_WIDTH_INPUT-1:0]};
      else
         return {1'b0, w_shift[FXP_WIDTH_INPUT-1:0]};
   endfunction

endpackage

// File: rtl/fxp_mul_stage.sv
// Front half of the MAC pipeline. S1 registers the operands and the last flag.
// S2 registers the full-width signed product. Both stages advance only on
// i_en. i_clear (like i_rst) drops whatever is in flight.
module fxp_mul_stage
   import fxp_pkg::*;
#(
   parameter int WIDTH_INPUT = FXP_WIDTH_INPUT
) (
   input  logic                          i_clk,
   input  logic                          i_rst,
   input  logic                          i_clear,
   input  logic                          i_en,
   input  logic                          i_valid,
   input  logic                          i_last,
   input  logic [WIDTH_INPUT-1:0]        i_a,
   input  logic [WIDTH_INPUT-1:0]        i_b,
   output logic                          o_valid,
   output logic                          o_last,
   output logic signed [2*WIDTH_INPUT-1:0] o_prod
);

   logic                            r_s1_valid;
   logic                            r_s1_last;
   logic signed [WIDTH_INPUT-1:0]   r_s1_a;
   logic signed [WIDTH_INPUT-1:0]   r_s1_b;
   logic                            r_s2_valid;
   logic                            r_s2_last;
   logic signed [2*WIDTH_INPUT-1:0] r_s2_prod;

   // Stage valid bits: cleared by reset or flush, otherwise shifted on enable.
   always_ff @(posedge i_clk) begin
      // NOTE: sequential state uses <= so every register samples pre-edge values.
      if (i_rst || i_clear) begin
         r_s1_valid <= 1'b0;
         r_s2_valid <= 1'b0;
      end else if (i_en) begin
         r_s1_valid <= i_valid;
         r_s2_valid <= r_s1_valid;
      end
   end

   // Payload registers: the valid bits qualify them, so they need no reset.
   always_ff @(posedge i_clk) begin
      // NOTE: datapath registers are left unreset on purpose; only control state is reset.
      if (i_en) begin
         r_s1_a    <= i_a;
         r_s1_b    <= i_b;
         r_s1_last <= i_last;
         r_s2_last <= r_s1_last;
         r_s2_prod <= (2*WIDTH_INPUT)'(r_s1_a) * (2*WIDTH_INPUT)'(r_s1_b);
      end
   end

   assign o_valid = r_s2_valid;
   assign o_last  = r_s2_last;
   assign o_prod  = r_s2_prod;

endmodule

// File: rtl/fixedpoint_mac_pipe.sv
// Pipelined signed fixed-point multiply-accumulate.
// Stage S1/S2 live in fxp_mul_stage. This level holds S3 (accumulator, beat
// counter, output register) and the valid/ready handshake.
// Build option: FXP_MAC_ROUND_EN enables round-half-up rescaling of the final sum.
// The module parameters must match the widths in fxp_pkg, because the rescale
// helper is sized by the package.
module fixedpoint_mac_pipe
   import fxp_pkg::*;
#(
   parameter int WIDTH_INPUT    = FXP_WIDTH_INPUT,
   parameter int WIDTH_FRACTION = FXP_WIDTH_FRACTION,
   parameter int WIDTH_ACC      = FXP_WIDTH_ACC,
   parameter int WIDTH_CNT      = FXP_WIDTH_CNT
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   clear_i,
   input  logic                   valid_i,
   output logic                   ready_o,
   input  logic [WIDTH_INPUT-1:0] data_a_i,
   input  logic [WIDTH_INPUT-1:0] data_b_i,
   input  logic                   last_i,
   output logic                   valid_o,
   input  logic                   ready_i,
   output logic [WIDTH_INPUT-1:0] data_o,
   output logic                   sat_o,
   output logic [WIDTH_CNT-1:0]   count_o
);

`ifdef FXP_MAC_ROUND_EN
   localparam logic ROUND = 1'b1;
`else
   localparam logic ROUND = 1'b0;
`endif

   logic                            w_en;
   logic                            w_s2_valid;
   logic                            w_s2_last;
   logic signed [2*WIDTH_INPUT-1:0] w_s2_prod;
   logic signed [WIDTH_ACC-1:0]     w_sum;
   logic [WIDTH_CNT-1:0]            w_cnt_inc;
   logic [WIDTH_INPUT:0]            w_sat_res;

   logic signed [WIDTH_ACC-1:0]     r_acc;
   logic [WIDTH_CNT-1:0]            r_cnt;
   logic                            r_valid_o;
   logic [WIDTH_INPUT-1:0]          r_data_o;
   logic                            r_sat_o;
   logic [WIDTH_CNT-1:0]            r_count_o;

   // The whole pipeline freezes while a result waits for downstream.
   assign w_en    = !r_valid_o || ready_i;
   assign ready_o = w_en;

   fxp_mul_stage #(
      .WIDTH_INPUT (WIDTH_INPUT)
   ) u_mul (
      .i_clk   (clk_i),
      .i_rst   (rst_i),
      .i_clear (clear_i),
      .i_en    (w_en),
      .i_valid (valid_i),
      .i_last  (last_i),
      .i_a     (data_a_i),
      .i_b     (data_b_i),
      .o_valid (w_s2_valid),
      .o_last  (w_s2_last),
      .o_prod  (w_s2_prod)
   );

   // Running sum including the beat now in S2, the saturating beat count and the rescaled result.
   always_comb begin
      // NOTE: defaults first so that no path through this block can infer a latch.
      w_sum     = r_acc + WIDTH_ACC'(w_s2_prod);
      w_cnt_inc = r_cnt;
      if (!(&r_cnt))
         w_cnt_inc = r_cnt + 1'b1;
      w_sat_res = fxp_sat(w_sum, WIDTH_FRACTION, ROUND);
   end

   // S3: accumulate non-last beats, emit and restart on the last beat, and hold everything while stalled.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_acc     <= '0;
         r_cnt     <= '0;
         r_valid_o <= 1'b0;
         r_data_o  <= '0;
         r_sat_o   <= 1'b0;
         r_count_o <= '0;
      end else if (clear_i) begin
         r_acc     <= '0;
         r_cnt     <= '0;
         r_valid_o <= 1'b0;
      end else if (w_en) begin
         r_valid_o <= w_s2_valid && w_s2_last;
         if (w_s2_valid) begin
            if (w_s2_last) begin
               r_sat_o   <= w_sat_res[WIDTH_INPUT];
               r_data_o  <= w_sat_res[WIDTH_INPUT-1:0];
               r_count_o <= w_cnt_inc;
               r_acc     <= '0;
               r_cnt     <= '0;
            end else begin
               r_acc     <= w_sum;
               r_cnt     <= w_cnt_inc;
            end
         end
      end
   end

   assign valid_o = r_valid_o;
   assign data_o  = r_data_o;
   assign sat_o   = r_sat_o;
   assign count_o = r_count_o;

endmodule

// File: tb/tb_fixedpoint_mac_pipe.sv
// Self-checking bench for fixedpoint_mac_pipe.
// A reference model works on whole vectors using integer arithmetic. It sees
// every accepted beat and queues the expected results. Directed steps and a
// randomized phase drive the DUT. Honours FXP_MAC_ROUND_EN like the RTL.
module tb_fixedpoint_mac_pipe;

   localparam int WI = 16;
   localparam int WF = 9;
   localparam int WC = 8;

`ifdef FXP_MAC_ROUND_EN
   localparam bit ROUND = 1'b1;
`else
   localparam bit ROUND = 1'b0;
`endif

   logic          clk_i = 1'b0;
   logic          rst_i, clear_i, valid_i, last_i, ready_i;
   logic          ready_o, valid_o, sat_o;
   logic [WI-1:0] data_a_i, data_b_i, data_o;
   logic [WC-1:0] count_o;

   int n_assert = 0;
   int n_fail   = 0;
   bit rand_ready = 1'b0;

   typedef struct {
      logic [WI-1:0] data;
      logic          sat;
      logic [WC-1:0] cnt;
   } res_t;

   res_t   exp_q[$];
   longint m_sum = 0;
   int     m_cnt = 0;

   fixedpoint_mac_pipe dut (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .clear_i  (clear_i),
      .valid_i  (valid_i),
      .ready_o  (ready_o),
      .data_a_i (data_a_i),
      .data_b_i (data_b_i),
      .last_i   (last_i),
      .valid_o  (valid_o),
      .ready_i  (ready_i),
      .data_o   (data_o),
      .sat_o    (sat_o),
      .count_o  (count_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Result of a finished vector: real-valued scaling by 2^-WF with floor
   // or round-half-up, then clipping to the signed output range.
   function automatic res_t model_result(input longint sum, input int cnt);
      res_t   r;
      longint v;
      v = sum;
      if (ROUND) v = v + (longint'(1) << (WF - 1));
      v = v >>> WF;
      r.sat = 1'b0;
      if (v > 32767)  begin v = 32767;  r.sat = 1'b1; end
      if (v < -32768) begin v = -32768; r.sat = 1'b1; end
      r.data = v[WI-1:0];
      r.cnt  = (cnt > 255) ? 8'hFF : cnt[WC-1:0];
      return r;
   endfunction

   // Model and scoreboard, sampled on the falling edge, between active edges.
   always @(negedge clk_i) begin
      res_t e;
      if (rst_i || clear_i) begin
         m_sum = 0;
         m_cnt = 0;
      end else if (valid_i && ready_o) begin
         m_sum = m_sum + longint'($signed(data_a_i)) * longint'($signed(data_b_i));
         m_cnt++;
         if (last_i) begin
            exp_q.push_back(model_result(m_sum, m_cnt));
            m_sum = 0;
            m_cnt = 0;
         end
      end
      if (!rst_i && valid_o && ready_i) begin
         if (exp_q.size() == 0) begin
            chk("unexpected result", 32'(valid_o), 32'h0);
         end else begin
            e = exp_q.pop_front();
            chk("sb data_o",  32'(data_o),  32'(e.data));
            chk("sb sat_o",   32'(sat_o),   32'(e.sat));
            chk("sb count_o", 32'(count_o), 32'(e.cnt));
         end
      end
   end

   // Random downstream back-pressure, only in the randomized phase.
   always @(posedge clk_i) begin
      if (rand_ready) begin
         #1;
         ready_i = ($urandom_range(0, 2) != 0);
      end
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // Present one beat and hold it until accepted. Returns at posedge+1.
   task automatic send(input logic [WI-1:0] a, input logic [WI-1:0] b, input logic last);
      bit got;
      got      = 1'b0;
      valid_i  = 1'b1;
      data_a_i = a;
      data_b_i = b;
      last_i   = last;
      for (int k = 0; k < 100 && !got; k++) begin
         @(negedge clk_i);
         got = ready_o;
         tick();
      end
      valid_i = 1'b0;
      last_i  = 1'b0;
      if (!got) chk("send timeout", 32'h0, 32'h1);
   endtask

   // Wait for the next valid_o and check it against fixed expected values.
   task automatic wait_result(input string tag, input logic [WI-1:0] d,
                              input logic s, input logic [WC-1:0] c);
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < 40 && !seen; k++) begin
         @(negedge clk_i);
         seen = valid_o;
      end
      chk({tag, " seen"}, 32'(seen), 32'h1);
      chk({tag, " data"}, 32'(data_o), 32'(d));
      chk({tag, " sat"},  32'(sat_o),  32'(s));
      chk({tag, " cnt"},  32'(count_o), 32'(c));
      tick();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int            idx;
      int            stall;
      bit            started;
      logic [WI-1:0] held;
      int            len;

      rst_i    = 1'b1;
      clear_i  = 1'b0;
      valid_i  = 1'b0;
      last_i   = 1'b0;
      ready_i  = 1'b1;
      data_a_i = '0;
      data_b_i = '0;
      repeat (3) tick();
      chk("reset valid_o", 32'(valid_o), 32'h0);
      chk("reset data_o",  32'(data_o),  32'h0);
      chk("reset sat_o",   32'(sat_o),   32'h0);
      chk("reset count_o", 32'(count_o), 32'h0);
      rst_i = 1'b0;
      @(negedge clk_i);
      chk("ready after reset", 32'(ready_o), 32'h1);
      tick();

      // 1: single beat, exact three-cycle latency.
      data_a_i = 16'h0300;
      data_b_i = 16'h0400;
      last_i   = 1'b1;
      valid_i  = 1'b1;
      tick();
      valid_i = 1'b0;
      last_i  = 1'b0;
      chk("t1 valid N+1", 32'(valid_o), 32'h0);
      tick();
      chk("t1 valid N+2", 32'(valid_o), 32'h0);
      tick();
      chk("t1 valid N+3", 32'(valid_o), 32'h1);
      chk("t1 data",      32'(data_o),  32'h0600);
      chk("t1 sat",       32'(sat_o),   32'h0);
      chk("t1 cnt",       32'(count_o), 32'h1);
      tick();

      // 2: four-beat vector of 1.0 * -1.0.
      for (int i = 0; i < 3; i++) begin
         send(16'h0200, 16'hFE00, 1'b0);
         chk("t2 no early valid", 32'(valid_o), 32'h0);
      end
      send(16'h0200, 16'hFE00, 1'b1);
      wait_result("t2", 16'hF800, 1'b0, 8'd4);

      // 3: positive and negative saturation.
      send(16'h7E00, 16'h7E00, 1'b1);
      wait_result("t3 pos", 16'h7FFF, 1'b1, 8'd1);
      send(16'h8000, 16'h7E00, 1'b1);
      wait_result("t3 neg", 16'h8000, 1'b1, 8'd1);

      // 4: rounding versus truncation.
      send(16'h0001, 16'h0100, 1'b1);
      wait_result("t4", ROUND ? 16'h0001 : 16'h0000, 1'b0, 8'd1);

      // 5: back-to-back one-beat vectors with a five-cycle downstream stall.
      idx     = 0;
      stall   = 0;
      started = 1'b0;
      held    = '0;
      for (int cyc = 0; cyc < 60 && idx < 4; cyc++) begin
         if (!started && valid_o) begin
            started = 1'b1;
            stall   = 5;
            held    = data_o;
         end
         ready_i  = (stall > 0) ? 1'b0 : 1'b1;
         valid_i  = 1'b1;
         last_i   = 1'b1;
         data_a_i = WI'((idx + 1) * 16'h0100);
         data_b_i = 16'h0200;
         @(negedge clk_i);
         if (stall > 0) begin
            chk("t5 ready_o stalled", 32'(ready_o), 32'h0);
            chk("t5 data_o held",     32'(data_o),  32'(held));
            stall--;
         end
         if (valid_i && ready_o) idx++;
         tick();
      end
      valid_i = 1'b0;
      last_i  = 1'b0;
      ready_i = 1'b1;
      repeat (10) tick();
      chk("t5 stall seen",     32'(started), 32'h1);
      chk("t5 all sent",       32'(idx), 32'd4);
      chk("t5 drained",        32'(exp_q.size()), 32'h0);

      // 6: flush mid-vector. A beat presented during the flush is dropped.
      send(16'h0200, 16'h0200, 1'b0);
      send(16'h0200, 16'h0200, 1'b0);
      clear_i  = 1'b1;
      valid_i  = 1'b1;
      last_i   = 1'b1;
      data_a_i = 16'h7E00;
      data_b_i = 16'h7E00;
      tick();
      clear_i = 1'b0;
      valid_i = 1'b0;
      last_i  = 1'b0;
      chk("t6 valid after clear", 32'(valid_o), 32'h0);
      send(16'h0200, 16'h0200, 1'b1);
      wait_result("t6", 16'h0200, 1'b0, 8'd1);
      repeat (8) tick();
      chk("t6 no extra result", 32'(exp_q.size()), 32'h0);

      // 7: reset mid-vector discards the partial sum.
      send(16'h0400, 16'h0400, 1'b0);
      send(16'h0400, 16'h0400, 1'b0);
      rst_i = 1'b1;
      repeat (2) tick();
      rst_i = 1'b0;
      chk("t7 count after rst", 32'(count_o), 32'h0);
      send(16'h0400, 16'h0200, 1'b1);
      wait_result("t7", 16'h0400, 1'b0, 8'd1);

      // 8: random vectors, random gaps and random back-pressure.
      rand_ready = 1'b1;
      for (int v = 0; v < 40; v++) begin
         len = $urandom_range(1, 6);
         for (int j = 0; j < len; j++) begin
            if ($urandom_range(0, 3) == 0) tick();
            send(WI'($urandom), WI'($urandom), (j == len - 1));
         end
      end
      rand_ready = 1'b0;
      #2;
      ready_i = 1'b1;
      repeat (20) tick();
      chk("random drained", 32'(exp_q.size()), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
